adc_sample_scheduler: RTL and testbench

Sequences the ADS1672 serial reader. Issues periodic single-cycle `measure` pulses, waits for the reader's completion strobe, and captures each 24-bit result into a small output FIFO with a valid/ready interface. Supports continuous or fixed-count bursts, per-conversion timeout, and sticky overrun/drop/timeout status. Sits between the reader and the downstream sample pipe / DMA packer.

---
 rtl/adc_sample_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// Sample scheduler for the ADS1672 reader: periodic measure pulses, conversion supervision and a FWFT output FIFO.
// Define ADC_SCHED_SEQNUM_EN to add m_seq, a run-relative sample index stored with each FIFO entry.

module adc_sample_scheduler #(
  parameter int DATA_WIDTH     = 24,
  parameter int FIFO_DEPTH     = 8,
  parameter int PERIOD_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run_start,
  input  logic                          run_stop,
  input  logic [PERIOD_WIDTH-1:0]       period,
  input  logic [15:0]                   num_samples,
  input  logic                          clear_flags,
  output logic                          measure,
  input  logic                          rd_done,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          running,
  output logic                          run_done,
  output logic                          overrun,
  output logic                          dropped,
  output logic                          timeout
`ifdef ADC_SCHED_SEQNUM_EN
  ,
  output logic [15:0]                   m_seq
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]           TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW:0]             FULL_LVL   = (LW + 1)'(FIFO_DEPTH);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MIN = PERIOD_WIDTH'(2);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    BUSY        = 2'd2,
    WAIT_PERIOD = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [PERIOD_WIDTH-1:0] per_m1_r;
  logic [PERIOD_WIDTH-1:0] pcnt_r;
  logic [TW-1:0]           tcnt_r;
  logic [15:0]             num_r;
  logic [15:0]             scnt_r;
  logic                    stop_pend_r;
  logic                    measure_r;
  logic                    running_r;
  logic                    run_done_r;
  logic                    overrun_r;
  logic                    dropped_r;
  logic                    timeout_r;

  logic                    per_last_s;
  logic                    to_last_s;
  logic                    end_pend_s;
  logic                    conv_done_s;
  logic                    conv_to_s;
  logic                    ovr_set_s;

  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [LW-1:0]           wptr_r;
  logic [LW-1:0]           rptr_r;
  logic [LW:0]             count_r;
  logic                    full_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    drop_s;

  assign per_last_s = (pcnt_r == per_m1_r);
  assign to_last_s  = (tcnt_r == TO_LAST);
  assign end_pend_s = stop_pend_r | run_stop | ((num_r != 16'd0) && (scnt_r == num_r));
  // A slot is missed whenever its boundary passes while a conversion is still open.
  assign ovr_set_s  = (state_r == BUSY) && per_last_s;

  // Next-state decode; rd_done takes priority over the timeout terminal count.
  always_comb begin
    state_nxt_s = state_r;
    conv_done_s = 1'b0;
    conv_to_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_start) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = BUSY;
      end
      BUSY: begin
        if (rd_done) begin
          conv_done_s = 1'b1;
          state_nxt_s = WAIT_PERIOD;
        end else if (to_last_s) begin
          conv_to_s   = 1'b1;
          state_nxt_s = WAIT_PERIOD;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      WAIT_PERIOD: begin
        if (end_pend_s) begin
          state_nxt_s = IDLE;
        end else if (per_last_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = WAIT_PERIOD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Run control: state, counters, latched run parameters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      per_m1_r    <= PERIOD_ONE;
      pcnt_r      <= {PERIOD_WIDTH{1'b0}};
      tcnt_r      <= {TW{1'b0}};
      num_r       <= 16'd0;
      scnt_r      <= 16'd0;
      stop_pend_r <= 1'b0;
      measure_r   <= 1'b0;
      running_r   <= 1'b0;
      run_done_r  <= 1'b0;
      overrun_r   <= 1'b0;
      dropped_r   <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      measure_r  <= (state_nxt_s == ISSUE);
      running_r  <= (state_nxt_s != IDLE);
      run_done_r <= (state_r == WAIT_PERIOD) && (state_nxt_s == IDLE);

      if ((state_r == IDLE) && run_start) begin
        per_m1_r <= ((period < PERIOD_MIN) ? PERIOD_MIN : period) - PERIOD_ONE;
        num_r    <= num_samples;
        scnt_r   <= 16'd0;
      end else if (conv_done_s && (scnt_r != 16'hFFFF)) begin
        scnt_r <= scnt_r + 16'd1;
      end

      if ((state_r == IDLE) || (state_nxt_s == IDLE)) begin
        stop_pend_r <= 1'b0;
      end else if (run_stop) begin
        stop_pend_r <= 1'b1;
      end

      // The ISSUE cycle is count 0, so the next ISSUE lands exactly one period later.
      case (state_r)
        ISSUE:             pcnt_r <= PERIOD_ONE;
        BUSY, WAIT_PERIOD: pcnt_r <= per_last_s ? {PERIOD_WIDTH{1'b0}} : pcnt_r + PERIOD_ONE;
        default:           pcnt_r <= {PERIOD_WIDTH{1'b0}};
      endcase

      case (state_r)
        ISSUE:   tcnt_r <= TW'(1);
        BUSY:    tcnt_r <= tcnt_r + TW'(1);
        default: tcnt_r <= {TW{1'b0}};
      endcase

      overrun_r <= ovr_set_s | (overrun_r & ~clear_flags);
      dropped_r <= drop_s    | (dropped_r & ~clear_flags);
      timeout_r <= conv_to_s | (timeout_r & ~clear_flags);
    end
  end

  assign full_s = (count_r == FULL_LVL);
  assign pop_s  = m_valid & m_ready;
  assign push_s = conv_done_s & (~full_s | pop_s);
  assign drop_s = conv_done_s & full_s & ~pop_s;

  // Output FIFO storage and pointers; push and pop are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wptr_r  <= {LW{1'b0}};
      rptr_r  <= {LW{1'b0}};
      count_r <= {(LW + 1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= rd_data;
        wptr_r        <= wptr_r + LW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + LW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (LW + 1)'(1);
        2'b01:   count_r <= count_r - (LW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef ADC_SCHED_SEQNUM_EN
  logic [15:0] seq_r;
  logic [15:0] seq_mem_r [FIFO_DEPTH];

  // Sequence index advances on every accepted rd_done, dropped or not, so gaps show downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_r <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        seq_mem_r[i] <= 16'd0;
      end
    end else begin
      if ((state_r == IDLE) && run_start) begin
        seq_r <= 16'd0;
      end else if (conv_done_s) begin
        seq_r <= seq_r + 16'd1;
      end
      if (push_s) begin
        seq_mem_r[wptr_r] <= seq_r;
      end
    end
  end

  assign m_seq = m_valid ? seq_mem_r[rptr_r] : 16'd0;
`endif

  assign measure    = measure_r;
  assign running    = running_r;
  assign run_done   = run_done_r;
  assign overrun    = overrun_r;
  assign dropped    = dropped_r;
  assign timeout    = timeout_r;
  assign fifo_level = count_r;
  assign m_valid    = (count_r != {(LW + 1){1'b0}});
  assign m_data     = m_valid ? mem_r[rptr_r] : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a latency-programmable reader model.
// Builds with or without ADC_SCHED_SEQNUM_EN.

module tb_adc_sample_scheduler;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        run_start   = 1'b0;
  logic        run_stop    = 1'b0;
  logic        clear_flags = 1'b0;
  logic        m_ready     = 1'b0;
  logic        rd_done     = 1'b0;
  logic [31:0] period      = 32'd0;
  logic [15:0] num_samples = 16'd0;
  logic [23:0] rd_data     = 24'd0;
  logic        measure, m_valid, running, run_done, overrun, dropped, timeout;
  logic [23:0] m_data;
  logic [3:0]  fifo_level;
`ifdef ADC_SCHED_SEQNUM_EN
  logic [15:0] m_seq;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_lat = 0;
  int cd     = 0;
  int rd_idx = 0;
  int s, s2;
  logic [23:0] rd_tab [16];

  int          meas_q[$];
  int          done_q[$];
  int          beat_cyc_q[$];
  logic [23:0] beat_q[$];
  logic [15:0] seq_q[$];

  adc_sample_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .run_start  (run_start),
    .run_stop   (run_stop),
    .period     (period),
    .num_samples(num_samples),
    .clear_flags(clear_flags),
    .measure    (measure),
    .rd_done    (rd_done),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .fifo_level (fifo_level),
    .running    (running),
    .run_done   (run_done),
    .overrun    (overrun),
    .dropped    (dropped),
    .timeout    (timeout)
`ifdef ADC_SCHED_SEQNUM_EN
    ,
    .m_seq      (m_seq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reader model; rd_done fires rd_lat cycles after the measure cycle.
  always @(negedge clk) begin
    if (measure) meas_q.push_back(cyc);
    if (run_done) done_q.push_back(cyc);
    if (m_valid && m_ready) begin
      beat_q.push_back(m_data);
      beat_cyc_q.push_back(cyc);
`ifdef ADC_SCHED_SEQNUM_EN
      seq_q.push_back(m_seq);
`endif
    end
    rd_done = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        rd_done = 1'b1;
        rd_data = rd_tab[rd_idx % 16];
        rd_idx  = rd_idx + 1;
      end
    end
    if (measure && (rd_lat > 0)) cd = rd_lat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic start_run(input logic [31:0] per, input logic [15:0] num, output int st);
    period      = per;
    num_samples = num;
    run_start   = 1'b1;
    st          = cyc;
    step(1);
    run_start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = done_q.size();
    int n  = 0;
    while ((done_q.size() == n0) && (n < budget)) begin
      step(1);
      n++;
    end
    check(tag, 32'(done_q.size() > n0), 32'd1);
  endtask

  task automatic clr_flags();
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
  endtask

  task automatic clear_q();
    meas_q.delete();
    done_q.delete();
    beat_q.delete();
    beat_cyc_q.delete();
    seq_q.delete();
  endtask

  function automatic logic [31:0] meas_at(input int i);
    if (i < meas_q.size()) return 32'(meas_q[i]);
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] done_at(input int i);
    if (i < done_q.size()) return 32'(done_q[i]);
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] beat_at(input int i);
    if (i < beat_q.size()) return {8'h00, beat_q[i]};
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] beat_cyc_at(input int i);
    if (i < beat_cyc_q.size()) return 32'(beat_cyc_q[i]);
    else return 32'hFFFF_FFFF;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rd_tab[i] = 24'd0;

    // Reset state
    step(3);
    check("rst_outs", {25'd0, measure, m_valid, running, run_done, overrun, dropped, timeout}, 32'd0);
    check("rst_level", {28'd0, fifo_level}, 32'd0);
    check("rst_data", {8'd0, m_data}, 32'd0);
    rst = 1'b0;
    step(2);

    // Fixed-count run, period 100, latency 30
    clear_q();
    rd_lat = 30; rd_idx = 0;
    rd_tab[0] = 24'hABCDEF; rd_tab[1] = 24'h000001; rd_tab[2] = 24'h800000;
    m_ready = 1'b1;
    start_run(32'd100, 16'd3, s);
    wait_done("t1_done", 400);
    check("t1_nmeas", 32'(meas_q.size()), 32'd3);
    check("t1_meas0", meas_at(0), 32'(s + 1));
    check("t1_meas1", meas_at(1), 32'(s + 101));
    check("t1_meas2", meas_at(2), 32'(s + 201));
    check("t1_nbeat", 32'(beat_q.size()), 32'd3);
    check("t1_beat0", beat_at(0), 32'h00ABCDEF);
    check("t1_beat1", beat_at(1), 32'h00000001);
    check("t1_beat2", beat_at(2), 32'h00800000);
    check("t1_beat0_cyc", beat_cyc_at(0), 32'(s + 32));
    check("t1_done_cyc", done_at(0), 32'(s + 233));
    step(2);
    check("t1_ndone", 32'(done_q.size()), 32'd1);
    check("t1_running", {31'd0, running}, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);

    // Overrun: period 20, latency 50
    step(5);
    clear_q();
    rd_lat = 50; rd_idx = 0;
    start_run(32'd20, 16'd2, s);
    wait_until(s + 20);
    check("t2_ovr_pre", {31'd0, overrun}, 32'd0);
    wait_until(s + 21);
    check("t2_ovr_set", {31'd0, overrun}, 32'd1);
    wait_done("t2_done", 300);
    check("t2_spacing", meas_at(1) - meas_at(0), 32'd60);
    check("t2_done_cyc", done_at(0), 32'(s + 113));
    clr_flags();
    check("t2_ovr_clr", {31'd0, overrun}, 32'd0);

    // FIFO full with downstream stalled
    step(5);
    clear_q();
    rd_lat = 5; rd_idx = 0;
    for (int i = 0; i < 16; i++) rd_tab[i] = 24'h000100 + 24'(i);
    m_ready = 1'b0;
    start_run(32'd20, 16'd10, s);
    wait_until(s + 166);
    check("t3_drop_pre", {31'd0, dropped}, 32'd0);
    wait_until(s + 167);
    check("t3_drop_set", {31'd0, dropped}, 32'd1);
    wait_done("t3_done", 100);
    check("t3_done_cyc", done_at(0), 32'(s + 188));
    check("t3_nmeas", 32'(meas_q.size()), 32'd10);
    check("t3_level_full", {28'd0, fifo_level}, 32'd8);
    m_ready = 1'b1;
    step(12);
    m_ready = 1'b0;
    check("t3_nbeat", 32'(beat_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_beat%0d", i), beat_at(i), 32'h100 + 32'(i));
`ifdef ADC_SCHED_SEQNUM_EN
      check($sformatf("t3_seq%0d", i), (i < seq_q.size()) ? {16'd0, seq_q[i]} : 32'hFFFF_FFFF, 32'(i));
`endif
    end
    check("t3_level_empty", {28'd0, fifo_level}, 32'd0);

    // Timeout: reader silent for the first conversion
    step(5);
    clr_flags();
    clear_q();
    rd_lat = 0; rd_idx = 0;
    m_ready = 1'b1;
    start_run(32'd100, 16'd0, s);
    wait_until(s + 4096);
    check("t4_to_pre", {31'd0, timeout}, 32'd0);
    wait_until(s + 4097);
    check("t4_to_set", {31'd0, timeout}, 32'd1);
    check("t4_level", {28'd0, fifo_level}, 32'd0);
    check("t4_nmeas1", 32'(meas_q.size()), 32'd1);
    rd_lat = 10;
    wait_until(s + 4115);
    run_stop = 1'b1;
    step(1);
    run_stop = 1'b0;
    wait_done("t4_done", 50);
    check("t4_meas1", meas_at(1), 32'(s + 4101));
    check("t4_done_cyc", done_at(0), 32'(s + 4116));
    check("t4_nbeat", 32'(beat_q.size()), 32'd1);
    check("t4_beat0", beat_at(0), 32'h100);

    // Continuous run stopped mid-conversion
    step(5);
    clr_flags();
    clear_q();
    rd_lat = 20; rd_idx = 0;
    start_run(32'd50, 16'd0, s);
    wait_until(s + 60);
    run_stop = 1'b1;
    step(1);
    run_stop = 1'b0;
    wait_done("t5_done", 50);
    check("t5_done_cyc", done_at(0), 32'(s + 73));
    wait_until(s + 200);
    check("t5_nmeas", 32'(meas_q.size()), 32'd2);
    check("t5_nbeat", 32'(beat_q.size()), 32'd2);
    check("t5_beat1", beat_at(1), 32'h101);
    check("t5_running", {31'd0, running}, 32'd0);

    // Reset mid-conversion, late rd_done, then a fresh run
    step(5);
    clear_q();
    rd_lat = 20; rd_idx = 0;
    start_run(32'd50, 16'd0, s);
    wait_until(s + 10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_rst_outs", {25'd0, measure, m_valid, running, run_done, overrun, dropped, timeout}, 32'd0);
    check("t6_rst_level", {28'd0, fifo_level}, 32'd0);
    wait_until(s + 30);
    check("t6_late_level", {28'd0, fifo_level}, 32'd0);
    check("t6_late_nbeat", 32'(beat_q.size()), 32'd0);
    check("t6_late_ndone", 32'(done_q.size()), 32'd0);
    start_run(32'd50, 16'd1, s2);
    wait_done("t6_done", 60);
    check("t6_meas", meas_at(1), 32'(s2 + 1));
    check("t6_done_cyc", done_at(0), 32'(s2 + 23));
    check("t6_beat0", beat_at(0), 32'h101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
